// File: rtl/icache_direct_mapped.sv
// Direct-mapped instruction cache between the single-cycle CPU fetch port and
// the block-wide instruction memory. A hit returns the word in the same cycle.
// A miss stalls the CPU, refills one 16-byte block, and then serves the fetch.
// Optional hit/miss counters are built when ICACHE_STATS_EN is defined.

module icache_direct_mapped #(
  parameter int unsigned ADDR_BITS  = 10,
  parameter int unsigned INDEX_BITS = 3
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic [31:0]          PC,
  output logic [31:0]          INSTRUCTION,
  output logic                 BUSYWAIT,
  output logic                 MEM_READ,
  output logic [ADDR_BITS-5:0] MEM_ADDRESS,
  input  logic [127:0]         MEM_READDATA,
  input  logic                 MEM_BUSYWAIT
`ifdef ICACHE_STATS_EN
  ,
  output logic [15:0]          HIT_COUNT,
  output logic [15:0]          MISS_COUNT
`endif
);

  localparam int unsigned TagBits   = ADDR_BITS - 4 - INDEX_BITS;
  localparam int unsigned NumBlocks = 1 << INDEX_BITS;

  typedef enum logic [0:0] {StIdle, StMemRead} state_e;

  state_e                  state_q;
  logic [NumBlocks-1:0]    valid_q;
  logic [TagBits-1:0]      tag_q  [NumBlocks];
  logic [127:0]            data_q [NumBlocks];
  logic [ADDR_BITS-5:0]    req_q;
  logic                    mem_read_q;
  logic [31:0]             instr_q;

  logic [1:0]              pc_word;
  logic [INDEX_BITS-1:0]   pc_index;
  logic [TagBits-1:0]      pc_tag;
  logic [INDEX_BITS-1:0]   req_index;
  logic [TagBits-1:0]      req_tag;
  logic [127:0]            hit_block;
  logic [31:0]             hit_word;
  logic                    hit;
  logic                    fill_done;
  logic                    unused_pc_bits;

  assign pc_word   = PC[3:2];
  assign pc_index  = PC[3+INDEX_BITS:4];
  assign pc_tag    = PC[ADDR_BITS-1:4+INDEX_BITS];
  assign req_index = req_q[INDEX_BITS-1:0];
  assign req_tag   = req_q[ADDR_BITS-5:INDEX_BITS];

  // Byte offset and the bits above the lookup window never affect the lookup.
  assign unused_pc_bits = ^{PC[31:ADDR_BITS], PC[1:0]};

  assign hit       = valid_q[pc_index] && (tag_q[pc_index] == pc_tag);
  assign hit_block = data_q[pc_index];

  // A refill lands on the edge where memory reports its data valid.
  assign fill_done = !RESET && (state_q == StMemRead) && !MEM_BUSYWAIT;

  // Select the addressed word out of the indexed block.
  always_comb begin
    hit_word = hit_block[31:0];
    unique case (pc_word)
      2'd0: hit_word = hit_block[31:0];
      2'd1: hit_word = hit_block[63:32];
      2'd2: hit_word = hit_block[95:64];
      2'd3: hit_word = hit_block[127:96];
      default: hit_word = hit_block[31:0];
    endcase
  end

  // CPU-facing outputs: served combinationally on a hit, otherwise stall and hold.
  always_comb begin
    BUSYWAIT    = 1'b0;
    INSTRUCTION = instr_q;
    if (RESET) begin
      BUSYWAIT    = 1'b0;
      INSTRUCTION = 32'h0;
    end else if (state_q == StMemRead) begin
      BUSYWAIT = 1'b1;
    end else if (hit) begin
      INSTRUCTION = hit_word;
    end else begin
      BUSYWAIT = 1'b1;
    end
  end

  assign MEM_READ    = mem_read_q;
  assign MEM_ADDRESS = req_q;

  // Control FSM with registered memory request, valid/tag update and held word.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q    <= StIdle;
      valid_q    <= '0;
      req_q      <= '0;
      mem_read_q <= 1'b0;
      instr_q    <= 32'h0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (hit) begin
            instr_q <= hit_word;
          end else begin
            req_q      <= {pc_tag, pc_index};
            mem_read_q <= 1'b1;
            state_q    <= StMemRead;
          end
        end
        StMemRead: begin
          // The fill always targets the latched request, not the current PC.
          if (!MEM_BUSYWAIT) begin
            valid_q[req_index] <= 1'b1;
            tag_q[req_index]   <= req_tag;
            mem_read_q         <= 1'b0;
            state_q            <= StIdle;
          end
        end
        default: begin
          state_q    <= StIdle;
          mem_read_q <= 1'b0;
        end
      endcase
    end
  end

  // Block data array; contents are qualified by valid_q so no reset is needed.
  always_ff @(posedge CLK) begin
    if (fill_done) begin
      data_q[req_index] <= MEM_READDATA;
    end
  end

`ifdef ICACHE_STATS_EN
  logic [15:0] hit_count_q;
  logic [15:0] miss_count_q;

  // Saturating counters: hits on every served IDLE edge, misses on each fill start.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      hit_count_q  <= 16'h0;
      miss_count_q <= 16'h0;
    end else if (state_q == StIdle) begin
      if (hit && (hit_count_q != 16'hFFFF)) begin
        hit_count_q <= hit_count_q + 16'h1;
      end
      if (!hit && (miss_count_q != 16'hFFFF)) begin
        miss_count_q <= miss_count_q + 16'h1;
      end
    end
  end

  assign HIT_COUNT  = hit_count_q;
  assign MISS_COUNT = miss_count_q;
`endif

endmodule

// File: tb/tb_icache_direct_mapped.sv
// Scoreboard bench for icache_direct_mapped: the driver issues fetches and
// queues the expected response; the monitor checks each served fetch.

module tb_icache_direct_mapped;

  logic         CLK;
  logic         RESET;
  logic [31:0]  PC;
  logic [31:0]  INSTRUCTION;
  logic         BUSYWAIT;
  logic         MEM_READ;
  logic [5:0]   MEM_ADDRESS;
  logic [127:0] MEM_READDATA;
  logic         MEM_BUSYWAIT;
`ifdef ICACHE_STATS_EN
  logic [15:0]  HIT_COUNT;
  logic [15:0]  MISS_COUNT;
`endif

  icache_direct_mapped dut (
    .CLK          (CLK),
    .RESET        (RESET),
    .PC           (PC),
    .INSTRUCTION  (INSTRUCTION),
    .BUSYWAIT     (BUSYWAIT),
    .MEM_READ     (MEM_READ),
    .MEM_ADDRESS  (MEM_ADDRESS),
    .MEM_READDATA (MEM_READDATA),
    .MEM_BUSYWAIT (MEM_BUSYWAIT)
`ifdef ICACHE_STATS_EN
    ,
    .HIT_COUNT    (HIT_COUNT),
    .MISS_COUNT   (MISS_COUNT)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int vectors = 0;
  int errors  = 0;
  bit stats_check = 1'b0;

  typedef struct {
    logic [31:0] instr;
    int          busy;
    logic        has_fill;
    logic [5:0]  fill;
  } exp_t;

  exp_t exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // Instruction memory model: block 0 holds 0A..0D, others B000_bbww.
  int mem_delay = 4;
  int mem_cnt   = 0;

  function automatic logic [127:0] block_data(input logic [5:0] blk);
    logic [127:0] d;
    for (int w = 0; w < 4; w++) begin
      if (blk == 6'd0) d[w*32 +: 32] = 32'h0000_000A + 32'(w);
      else             d[w*32 +: 32] = 32'hB000_0000 | (32'(blk) << 8) | 32'(w);
    end
    return d;
  endfunction

  always @(posedge CLK) mem_cnt <= (MEM_READ === 1'b1) ? mem_cnt + 1 : 0;
  assign MEM_BUSYWAIT = (MEM_READ === 1'b1) && (mem_cnt < mem_delay);
  assign MEM_READDATA = block_data(MEM_ADDRESS);

  // Monitor: accumulate stall behaviour, then score each served fetch.
  int         busy_cnt = 0;
  int         mr_cnt   = 0;
  logic [5:0] first_addr = '0;
  bit         addr_moved = 1'b0;

  always @(negedge CLK) begin
    exp_t e;
    if (RESET) begin
      busy_cnt   = 0;
      mr_cnt     = 0;
      addr_moved = 1'b0;
    end else if (BUSYWAIT) begin
      busy_cnt++;
      if (MEM_READ) begin
        if (mr_cnt == 0) first_addr = MEM_ADDRESS;
        else if (MEM_ADDRESS != first_addr) addr_moved = 1'b1;
        mr_cnt++;
      end
    end else if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("instruction", INSTRUCTION, e.instr);
      check("busy_cycles", busy_cnt, e.busy);
      check("mem_read_at_serve", {31'b0, MEM_READ}, 32'h0);
      if (e.has_fill) begin
        check("mem_read_cycles", mr_cnt, e.busy - 1);
        check("fill_address", {26'b0, first_addr}, {26'b0, e.fill});
        check("fill_address_stable", {31'b0, addr_moved}, 32'h0);
      end else begin
        check("no_mem_read", mr_cnt, 0);
      end
      busy_cnt   = 0;
      mr_cnt     = 0;
      addr_moved = 1'b0;
    end
  end

  // Issue one fetch and hold PC until served; optionally wander PC mid-miss.
  task automatic fetch(input logic [31:0] pc, input logic [31:0] instr, input int busy,
                       input logic has_fill, input logic [5:0] fill, input logic toggle);
    exp_t e;
    @(posedge CLK);
    #1;
    PC         = pc;
    e.instr    = instr;
    e.busy     = busy;
    e.has_fill = has_fill;
    e.fill     = fill;
    exp_q.push_back(e);
    for (int k = 0; k < 100; k++) begin
      @(negedge CLK);
`ifdef ICACHE_STATS_EN
      if (stats_check) begin
        check("hit_count", {16'b0, HIT_COUNT}, 32'd4);
        check("miss_count", {16'b0, MISS_COUNT}, 32'd1);
      end
`endif
      stats_check = 1'b0;
      if (!BUSYWAIT) return;
      if (toggle && k == 3) begin
        @(posedge CLK);
        #1;
        PC = 32'h0000_0040;
      end
      if (toggle && k == 6) begin
        @(posedge CLK);
        #1;
        PC = pc;
      end
    end
    errors++;
    $display("FAIL fetch_timeout: pc %h still stalled after 100 cycles, expected service", pc);
  endtask

  initial begin
    RESET = 1'b1;
    PC    = 32'h0;

    // Reset holds outputs quiet even with a missing PC presented.
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    check("reset_busywait", {31'b0, BUSYWAIT}, 32'h0);
    check("reset_instruction", INSTRUCTION, 32'h0);
    check("reset_mem_read", {31'b0, MEM_READ}, 32'h0);
    check("reset_mem_address", {26'b0, MEM_ADDRESS}, 32'h0);

    // Test 1: cold miss at 0x000, memory stalls 4 cycles.
    @(posedge CLK);
    #1;
    RESET     = 1'b0;
    mem_delay = 4;
    @(negedge CLK);
    check("cold_miss_busywait", {31'b0, BUSYWAIT}, 32'h1);
    check("cold_miss_no_read_yet", {31'b0, MEM_READ}, 32'h0);
    fetch(32'h000, 32'h0000_000A, 6, 1'b1, 6'h00, 1'b0);

    // Test 2: hits on the rest of the block.
    fetch(32'h004, 32'h0000_000B, 0, 1'b0, 6'h00, 1'b0);
    fetch(32'h008, 32'h0000_000C, 0, 1'b0, 6'h00, 1'b0);
    fetch(32'h00C, 32'h0000_000D, 0, 1'b0, 6'h00, 1'b0);

    // Test 3: conflict on index 0 evicts and re-fetches.
    stats_check = 1'b1;
    mem_delay   = 1;
    fetch(32'h080, 32'hB000_0800, 3, 1'b1, 6'h08, 1'b0);
    mem_delay   = 0;
    fetch(32'h000, 32'h0000_000A, 2, 1'b1, 6'h00, 1'b0);

    // Test 4: long stall while PC wanders; fill uses the latched address.
    mem_delay = 10;
    fetch(32'h100, 32'hB000_1000, 12, 1'b1, 6'h10, 1'b1);
    fetch(32'h104, 32'hB000_1001, 0, 1'b0, 6'h00, 1'b0);
    mem_delay = 1;
    fetch(32'h040, 32'hB000_0400, 3, 1'b1, 6'h04, 1'b0);
    fetch(32'h04C, 32'hB000_0403, 0, 1'b0, 6'h00, 1'b0);

    // Test 5: reset lands on the edge where memory returns data.
    mem_delay = 2;
    @(posedge CLK);
    #1;
    PC = 32'h080;
    @(negedge CLK);
    check("abort_miss_busywait", {31'b0, BUSYWAIT}, 32'h1);
    repeat (3) @(posedge CLK);
    #1;
    RESET = 1'b1;
    @(negedge CLK);
    check("abort_read_active", {31'b0, MEM_READ}, 32'h1);
    check("abort_req_address", {26'b0, MEM_ADDRESS}, 32'h08);
    check("abort_reset_busywait", {31'b0, BUSYWAIT}, 32'h0);
    check("abort_reset_instruction", INSTRUCTION, 32'h0);
    @(posedge CLK);
    @(negedge CLK);
    check("abort_mem_read_cleared", {31'b0, MEM_READ}, 32'h0);
    check("abort_mem_address_cleared", {26'b0, MEM_ADDRESS}, 32'h0);
    @(posedge CLK);
    #1;
    RESET     = 1'b0;
    mem_delay = 1;
    fetch(32'h080, 32'hB000_0800, 3, 1'b1, 6'h08, 1'b0);
    fetch(32'h000, 32'h0000_000A, 3, 1'b1, 6'h00, 1'b0);
    fetch(32'h040, 32'hB000_0400, 3, 1'b1, 6'h04, 1'b0);

    @(posedge CLK);
    @(negedge CLK);
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
